// File: rtl/axis_dac_pkg.sv
// Shared definitions for the AXI4-Stream to DDR LVDS DAC transmit path.
package axis_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dac_state_e;

  localparam int UNDERRUN_CNT_W = 32;

  // Clamp a signed in_w-bit value (carried in 32 bits) into the signed out_w-bit range.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x,
                                                    input int in_w,
                                                    input int out_w);
    logic signed [31:0] xs;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    xs = (x <<< (32 - in_w)) >>> (32 - in_w);
    hi = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (xs > hi) begin
      return hi;
    end else if (xs < lo) begin
      return lo;
    end else begin
      return xs;
    end
  endfunction

endpackage

// File: rtl/dac_oddr_bank.sv
// DDR output stage: one ODDR (SAME_EDGE) plus differential buffer per DAC pin,
// and a forwarded clock built from an ODDR with D1=1, D2=0. The registers are
// behavioural stand-ins for the vendor primitives and are deliberately not reset.
module dac_oddr_bank #(
  parameter int DAC_DATA_WIDTH = 14
) (
  input  logic                        aclk,
  input  logic [DAC_DATA_WIDTH-1:0]   dac_word,
  output logic [DAC_DATA_WIDTH/2-1:0] dac_p,
  output logic [DAC_DATA_WIDTH/2-1:0] dac_n,
  output logic                        dac_clk_p,
  output logic                        dac_clk_n
);

  localparam int NPINS = DAC_DATA_WIDTH / 2;

  for (genvar j = 0; j < NPINS; j++) begin : g_pin
    logic d1_q;
    logic d2_q;
    logic q;

    // Capture both halves on the rising edge (SAME_EDGE); bit 2j goes out first.
    always_ff @(posedge aclk) begin
      d1_q <= dac_word[2*j];
      d2_q <= dac_word[2*j+1];
    end

    assign q        = aclk ? d1_q : d2_q;
    assign dac_p[j] = q;
    assign dac_n[j] = ~q;
  end

  logic clk_d1_q;
  logic clk_d2_q;
  logic clk_q;

  // Forwarded clock: high on the rising half, low on the falling half.
  always_ff @(posedge aclk) begin
    clk_d1_q <= 1'b1;
    clk_d2_q <= 1'b0;
  end

  assign clk_q     = aclk ? clk_d1_q : clk_d2_q;
  assign dac_clk_p = clk_q;
  assign dac_clk_n = ~clk_q;

endmodule

// File: rtl/axis_dac.sv
// AXI4-Stream sample sink driving a DDR LVDS DAC bus.
//
// state | meaning
// IDLE  | streaming off, tready low, output forced to 0
// PRIME | accepting the first beat, output still 0
// RUN   | one buffer entry popped per cycle; empty buffer counts an underrun
module axis_dac
  import axis_dac_pkg::*;
#(
  parameter int DAC_DATA_WIDTH   = 14,
  parameter int AXIS_TDATA_WIDTH = 16,
  parameter bit HOLD_LAST        = 1'b1
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [DAC_DATA_WIDTH/2-1:0] dac_p,
  output logic [DAC_DATA_WIDTH/2-1:0] dac_n,
  output logic                        dac_clk_p,
  output logic                        dac_clk_n,
  output logic [DAC_DATA_WIDTH-1:0]   dac_word,
  output logic                        running,
  output logic [UNDERRUN_CNT_W-1:0]   underrun_count
);

  dac_state_e state;
  dac_state_e state_nxt;

  logic [AXIS_TDATA_WIDTH-1:0] buf_mem [2];
  logic                        rd_ptr;
  logic                        wr_ptr;
  logic [1:0]                  buf_cnt;
  logic [1:0]                  buf_cnt_nxt;

  logic [AXIS_TDATA_WIDTH-1:0] pipe_data;
  logic                        pipe_valid;
  logic                        pipe_under;
  logic [DAC_DATA_WIDTH-1:0]   last_sample;

  logic                        push;
  logic                        pop_due;
  logic                        pop_hit;
  logic                        underrun;
  logic                        flush;
  logic                        tready_d;
  logic                        running_d;
  logic signed [31:0]          sat_full;
  logic [DAC_DATA_WIDTH-1:0]   sat_word;

  assign push = s_axis_tvalid && s_axis_tready;

  // State register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: enable gates everything, the first accepted beat starts RUN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (enable) state_nxt = ST_PRIME;
      ST_PRIME: begin
        if (!enable) begin
          state_nxt = ST_IDLE;
        end else if (push) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN:   if (!enable) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Per-state controls: pop scheduling, underrun detect, flush and next ready/running.
  always_comb begin
    pop_due     = (state == ST_RUN) && enable;
    pop_hit     = pop_due && (buf_cnt != 2'd0);
    underrun    = pop_due && (buf_cnt == 2'd0);
    flush       = (state_nxt == ST_IDLE);
    buf_cnt_nxt = flush ? 2'd0 : (buf_cnt + {1'b0, push} - {1'b0, pop_hit});
    tready_d    = !flush && (buf_cnt_nxt < 2'd2);
    running_d   = (state_nxt == ST_RUN);
    sat_full    = sat_signed(32'(signed'(pipe_data)), AXIS_TDATA_WIDTH, DAC_DATA_WIDTH);
    sat_word    = sat_full[DAC_DATA_WIDTH-1:0];
  end

  // Skid buffer storage; contents are don't-care while the count says empty.
  always_ff @(posedge aclk) begin
    if (push && !flush) begin
      buf_mem[wr_ptr] <= s_axis_tdata;
    end
  end

  // Skid buffer pointers and occupancy; a beat landing on the flush edge is dropped.
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      rd_ptr  <= 1'b0;
      wr_ptr  <= 1'b0;
      buf_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop_hit) rd_ptr <= ~rd_ptr;
      buf_cnt <= buf_cnt_nxt;
    end
  end

  // Pop stage: carries either a sample or an underrun marker to the output register.
  always_ff @(posedge aclk) begin
    if (!aresetn || flush) begin
      pipe_data  <= '0;
      pipe_valid <= 1'b0;
      pipe_under <= 1'b0;
    end else begin
      pipe_valid <= pop_hit;
      pipe_under <= underrun;
      if (pop_hit) pipe_data <= buf_mem[rd_ptr];
    end
  end

  // Saturate/register stage feeding the DDR bank; underruns repeat or zero the output.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dac_word    <= '0;
      last_sample <= '0;
    end else if (flush) begin
      dac_word <= '0;
    end else if (pipe_valid) begin
      dac_word    <= sat_word;
      last_sample <= sat_word;
    end else if (pipe_under) begin
      dac_word <= HOLD_LAST ? last_sample : '0;
    end else begin
      dac_word <= '0;
    end
  end

  // Underrun counter: cleared when a new session starts, saturates at all-ones.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      underrun_count <= '0;
    end else if ((state == ST_IDLE) && enable) begin
      underrun_count <= '0;
    end else if (underrun && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axis_tready <= 1'b0;
      running       <= 1'b0;
    end else begin
      s_axis_tready <= tready_d;
      running       <= running_d;
    end
  end

  dac_oddr_bank #(
    .DAC_DATA_WIDTH(DAC_DATA_WIDTH)
  ) u_oddr_bank (
    .aclk      (aclk),
    .dac_word  (dac_word),
    .dac_p     (dac_p),
    .dac_n     (dac_n),
    .dac_clk_p (dac_clk_p),
    .dac_clk_n (dac_clk_n)
  );

endmodule

// File: tb/tb_axis_dac.sv
// Self-checking bench for axis_dac: two instances (HOLD_LAST=1 and 0) share one
// stimulus stream and are compared against a queue-based reference model.
module tb_axis_dac;

  localparam int DW = 14;
  localparam int AW = 16;
  localparam int NP = DW / 2;
  localparam int M_IDLE = 0;
  localparam int M_PRIME = 1;
  localparam int M_RUN = 2;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [AW-1:0] s_axis_tdata = '0;

  logic          tready_h, tready_z;
  logic [NP-1:0] dac_p_h, dac_n_h, dac_p_z, dac_n_z;
  logic          clk_p_h, clk_n_h, clk_p_z, clk_n_z;
  logic [DW-1:0] word_h, word_z;
  logic          running_h, running_z;
  logic [31:0]   ucnt_h, ucnt_z;

  int checks = 0;
  int errors = 0;

  // reference model
  int          m_st = M_IDLE;
  logic [15:0] m_q[$];
  int          m_pk = 0;          // 0 nothing, 1 sample, 2 underrun
  logic [15:0] m_pd = '0;
  logic [13:0] m_last = '0;
  logic [13:0] m_word_h = '0;
  logic [13:0] m_word_z = '0;
  logic [31:0] m_cnt = '0;
  logic        m_tready = 1'b0;
  logic        m_running = 1'b0;

  always #5 aclk = ~aclk;

  axis_dac #(.DAC_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(AW), .HOLD_LAST(1'b1)) dut_h (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready_h),
    .dac_p(dac_p_h), .dac_n(dac_n_h), .dac_clk_p(clk_p_h), .dac_clk_n(clk_n_h),
    .dac_word(word_h), .running(running_h), .underrun_count(ucnt_h)
  );

  axis_dac #(.DAC_DATA_WIDTH(DW), .AXIS_TDATA_WIDTH(AW), .HOLD_LAST(1'b0)) dut_z (
    .aclk(aclk), .aresetn(aresetn), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(tready_z),
    .dac_p(dac_p_z), .dac_n(dac_n_z), .dac_clk_p(clk_p_z), .dac_clk_n(clk_n_z),
    .dac_word(word_z), .running(running_z), .underrun_count(ucnt_z)
  );

  function automatic logic [13:0] ref_sat(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v > 8191) v = 8191;
    else if (v < -8192) v = -8192;
    return 14'(v);
  endfunction

  // Drive one cycle of inputs, advance past the rising edge and update the model.
  task automatic step(input logic en, input logic v, input logic [15:0] d, output logic hs);
    int  nst;
    logic fl;
    enable = en;
    s_axis_tvalid = v;
    s_axis_tdata = d;
    hs = v && m_tready;
    @(posedge aclk);
    if (!aresetn) begin
      m_st = M_IDLE; m_q.delete(); m_pk = 0; m_last = '0;
      m_word_h = '0; m_word_z = '0; m_cnt = '0; m_tready = 1'b0; m_running = 1'b0;
      hs = 1'b0;
    end else begin
      if (m_st == M_IDLE) nst = en ? M_PRIME : M_IDLE;
      else if (!en) nst = M_IDLE;
      else if (m_st == M_PRIME) nst = hs ? M_RUN : M_PRIME;
      else nst = M_RUN;
      fl = (nst == M_IDLE);
      if (fl || m_pk == 0) begin
        m_word_h = '0; m_word_z = '0;
      end else if (m_pk == 1) begin
        m_word_h = ref_sat(m_pd); m_word_z = ref_sat(m_pd); m_last = ref_sat(m_pd);
      end else begin
        m_word_h = m_last; m_word_z = '0;
      end
      if (fl) begin
        m_q.delete(); m_pk = 0;
        if (hs) hs = 1'b0;
      end else begin
        if (m_st == M_RUN) begin
          if (m_q.size() > 0) begin
            m_pd = m_q.pop_front(); m_pk = 1;
          end else begin
            m_pk = 2;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
          end
        end else begin
          m_pk = 0;
        end
        if (hs) m_q.push_back(d);
      end
      if (m_st == M_IDLE && en) m_cnt = '0;
      m_tready = !fl && (m_q.size() < 2);
      m_running = (nst == M_RUN);
      m_st = nst;
    end
    #1;
  endtask

  task automatic test_reset;
    logic hs;
    aresetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom), hs);
      checks++;
      if ({tready_h, running_h, word_h, ucnt_h} !== {1'b0, 1'b0, 14'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state_h: got tready=%0b run=%0b word=%h cnt=%0d exp all zero",
                 tready_h, running_h, word_h, ucnt_h);
      end
      checks++;
      if ({tready_z, running_z, word_z, ucnt_z} !== {1'b0, 1'b0, 14'h0, 32'h0}) begin
        errors++;
        $display("FAIL reset_state_z: got tready=%0b run=%0b word=%h cnt=%0d exp all zero",
                 tready_z, running_z, word_z, ucnt_z);
      end
    end
    aresetn = 1'b1;
    step(1'b0, 1'b1, 16'h1234, hs);
    checks++;
    if (tready_h !== 1'b0 || word_h !== 14'h0) begin
      errors++;
      $display("FAIL idle_outputs: got tready=%0b word=%h exp 0 0", tready_h, word_h);
    end
  endtask

  task automatic test_stream;
    logic hs;
    step(1'b1, 1'b0, 16'h0, hs);
    checks++;
    if (tready_h !== 1'b1 || running_h !== 1'b0) begin
      errors++;
      $display("FAIL prime_entry: got tready=%0b run=%0b exp 1 0", tready_h, running_h);
    end
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b1, 16'(i), hs);
      checks++;
      if (word_h !== m_word_h || word_z !== m_word_z || running_h !== m_running) begin
        errors++;
        $display("FAIL stream_cycle%0d: got word_h=%h word_z=%h run=%0b exp %h %h %0b",
                 i, word_h, word_z, running_h, m_word_h, m_word_z, m_running);
      end
      if (i == 0) begin
        checks++;
        if (running_h !== 1'b1) begin
          errors++;
          $display("FAIL stream_running: got %0b exp 1", running_h);
        end
      end
      if (i == 3 || i == 29) begin
        checks++;
        if (word_h !== 14'(i - 2)) begin
          errors++;
          $display("FAIL stream_latency%0d: got %h exp %h", i, word_h, 14'(i - 2));
        end
      end
    end
    checks++;
    if (ucnt_h !== 32'd0) begin
      errors++;
      $display("FAIL stream_no_underrun: got %0d exp 0", ucnt_h);
    end
  endtask

  task automatic test_saturation;
    logic        hs;
    logic [15:0] sv [4] = '{16'h7FFF, 16'h8000, 16'h1FFF, 16'hE000};
    logic [13:0] ev [4] = '{14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000};
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, (k < 4) ? sv[k] : 16'h0, hs);
      if (k >= 2) begin
        checks++;
        if (word_h !== ev[k-2] || word_z !== ev[k-2]) begin
          errors++;
          $display("FAIL saturate%0d: got h=%h z=%h exp %h", k - 2, word_h, word_z, ev[k-2]);
        end
      end
    end
  endtask

  task automatic test_underrun;
    logic        hs;
    logic        vv [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] dd [7] = '{16'd5, 16'h7777, 16'h7777, 16'h7777, 16'd6, 16'd7, 16'd8};
    logic [13:0] eh [7] = '{14'h0, 14'h0, 14'd5, 14'd5, 14'd5, 14'd5, 14'd6};
    logic [13:0] ez [7] = '{14'h0, 14'h0, 14'd5, 14'd0, 14'd0, 14'd0, 14'd6};
    for (int k = 0; k < 7; k++) begin
      step(1'b1, vv[k], dd[k], hs);
      if (k >= 2) begin
        checks++;
        if (word_h !== eh[k]) begin
          errors++;
          $display("FAIL underrun_hold%0d: got %h exp %h", k, word_h, eh[k]);
        end
        checks++;
        if (word_z !== ez[k]) begin
          errors++;
          $display("FAIL underrun_zero%0d: got %h exp %h", k, word_z, ez[k]);
        end
      end
    end
    checks++;
    if (ucnt_h !== 32'd3 || ucnt_z !== 32'd3 || running_h !== 1'b1) begin
      errors++;
      $display("FAIL underrun_count: got h=%0d z=%0d run=%0b exp 3 3 1", ucnt_h, ucnt_z, running_h);
    end
  endtask

  task automatic test_disable;
    logic hs;
    step(1'b1, 1'b1, 16'h0111, hs);
    step(1'b1, 1'b1, 16'h0222, hs);
    step(1'b0, 1'b1, 16'h0333, hs);
    checks++;
    if (running_h !== 1'b0 || tready_h !== 1'b0) begin
      errors++;
      $display("FAIL disable_state: got run=%0b tready=%0b exp 0 0", running_h, tready_h);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), hs);
      checks++;
      if (word_h !== 14'h0 || word_z !== 14'h0 || tready_h !== 1'b0 || ucnt_h !== m_cnt) begin
        errors++;
        $display("FAIL disable_idle%0d: got word=%h/%h tready=%0b cnt=%0d exp 0 0 0 %0d",
                 k, word_h, word_z, tready_h, ucnt_h, m_cnt);
      end
    end
    step(1'b1, 1'b0, 16'h0, hs);
    checks++;
    if (ucnt_h !== 32'd0 || ucnt_z !== 32'd0 || tready_h !== 1'b1) begin
      errors++;
      $display("FAIL reenable_clear: got cnt=%0d/%0d tready=%0b exp 0 0 1", ucnt_h, ucnt_z, tready_h);
    end
    step(1'b1, 1'b1, 16'h0444, hs);
    step(1'b1, 1'b1, 16'h0555, hs);
    step(1'b1, 1'b1, 16'h0666, hs);
    checks++;
    if (word_h !== 14'h0444 || word_z !== 14'h0444) begin
      errors++;
      $display("FAIL reprime_first: got h=%h z=%h exp 0444", word_h, word_z);
    end
  endtask

  task automatic test_back_to_back;
    logic hs;
    int   sent = 0;
    int   cyc = 0;
    while (sent < 1000 && cyc < 6000) begin
      step(1'b1, ($urandom_range(0, 3) != 0), 16'($urandom), hs);
      if (hs) sent++;
      cyc++;
      checks++;
      if (word_h !== m_word_h || word_z !== m_word_z || tready_h !== m_tready ||
          ucnt_h !== m_cnt || ucnt_z !== m_cnt) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got word=%h/%h tready=%0b cnt=%0d/%0d exp %h/%h %0b %0d",
                 cyc, word_h, word_z, tready_h, ucnt_h, ucnt_z, m_word_h, m_word_z, m_tready, m_cnt);
      end
    end
    checks++;
    if (sent != 1000) begin
      errors++;
      $display("FAIL b2b_budget: got %0d beats exp 1000", sent);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 16'h0, hs);
      checks++;
      if (word_h !== m_word_h || word_z !== m_word_z) begin
        errors++;
        $display("FAIL b2b_drain%0d: got %h/%h exp %h/%h", k, word_h, word_z, m_word_h, m_word_z);
      end
    end
  endtask

  task automatic test_pins;
    logic hs;
    for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 16'hEAAA, hs);
    checks++;
    if (word_h !== 14'h2AAA) begin
      errors++;
      $display("FAIL pin_word: got %h exp 2aaa", word_h);
    end
    checks++;
    if (dac_p_h !== 7'h00 || dac_n_h !== 7'h7F || clk_p_h !== 1'b1 || clk_n_h !== 1'b0) begin
      errors++;
      $display("FAIL pin_rise: got p=%h n=%h clk=%0b%0b exp 00 7f 10", dac_p_h, dac_n_h, clk_p_h, clk_n_h);
    end
    @(negedge aclk);
    #1;
    checks++;
    if (dac_p_h !== 7'h7F || dac_n_h !== 7'h00 || clk_p_h !== 1'b0 || clk_n_h !== 1'b1) begin
      errors++;
      $display("FAIL pin_fall: got p=%h n=%h clk=%0b%0b exp 7f 00 01", dac_p_h, dac_n_h, clk_p_h, clk_n_h);
    end
  endtask

  task automatic test_reset_mid;
    logic hs;
    step(1'b1, 1'b1, 16'h0321, hs);
    aresetn = 1'b0;
    step(1'b1, 1'b1, 16'h0432, hs);
    checks++;
    if ({tready_h, running_h, word_h, ucnt_h} !== {1'b0, 1'b0, 14'h0, 32'h0}) begin
      errors++;
      $display("FAIL reset_mid: got tready=%0b run=%0b word=%h cnt=%0d exp all zero",
               tready_h, running_h, word_h, ucnt_h);
    end
    aresetn = 1'b1;
    step(1'b0, 1'b0, 16'h0, hs);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_underrun();
    test_disable();
    test_back_to_back();
    test_pins();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_dac.md
Name: axis_dac

Overview:
- Transmit-side counterpart of the ADC capture path: accepts an AXI4-Stream of signed 16-bit samples and drives a DDR LVDS DAC bus.
- Each DAC pin carries two bits per aclk, bit 2j on the rising edge and bit 2j+1 on the falling edge, plus a forwarded LVDS clock.
- Contains a 2-entry input skid buffer, a saturating width converter, an enable/prime/run state machine and underrun accounting.
- Sits between the DSP/DMA stream fabric and the DAC connector.

Parameters:
- DAC_DATA_WIDTH, 14, DAC sample width. Must be even and at most AXIS_TDATA_WIDTH.
- AXIS_TDATA_WIDTH, 16, input stream width, two's complement.
- HOLD_LAST, 1, underrun policy: 1 repeats the last sample, 0 outputs midscale (0).

Ports:
- aclk  in  1  sample clock; one sample per cycle.
- aresetn  in  1  synchronous active-low reset.
- enable  in  1  level; high enables streaming.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  signed sample.
- s_axis_tvalid  in  1  AXIS valid.
- s_axis_tready  out  1  AXIS ready, registered.
- dac_p  out  DAC_DATA_WIDTH/2  LVDS data, positive leg.
- dac_n  out  DAC_DATA_WIDTH/2  LVDS data, negative leg.
- dac_clk_p  out  1  forwarded clock, positive leg.
- dac_clk_n  out  1  forwarded clock, negative leg.
- dac_word  out  DAC_DATA_WIDTH  registered word presented to the DDR output stage (verification visibility).
- running  out  1  high in RUN.
- underrun_count  out  32  saturating count of underrun cycles.

Behaviour:
- Reset (aresetn low at a rising edge): state IDLE, skid buffer empty, s_axis_tready=0, dac_word=0, running=0, underrun_count=0, last-sample register=0.
- States:
  - IDLE: tready=0, dac_word forced to 0. enable=1 moves to PRIME.
  - PRIME: tready=1 while the buffer is not full, output stays 0. The first accepted beat moves to RUN.
  - RUN: each cycle pops one buffer entry into the output pipeline.
  - enable=0 in PRIME or RUN moves to IDLE at the next edge, flushes the buffer and drives dac_word=0 on the following cycle.
- Handshake:
  - A beat transfers when s_axis_tvalid and s_axis_tready are both high at a rising edge.
  - s_axis_tready is registered and equals (state != IDLE) && (buffer occupancy after this edge < 2).
  - tdata is ignored when tvalid=0.
  - A beat transferred on the same edge that enable is sampled low is discarded by the flush.
- Skid buffer: 2 entries, FIFO order. A push and a pop on the same edge leave occupancy unchanged. No overflow is possible because tready is deasserted when the buffer is full.
- Width conversion: saturate the signed AXIS_TDATA_WIDTH value to [-2^(DAC_DATA_WIDTH-1), 2^(DAC_DATA_WIDTH-1)-1]. With defaults: 16'sh7FFF becomes 14'h1FFF, 16'sh8000 becomes 14'h2000, and in-range values pass unchanged. Output format is two's complement (no offset binary).
- Latency: a beat accepted at edge N into an empty buffer in RUN appears on dac_word at edge N+2 (pop stage, then saturate/register stage). Pins follow dac_word through the output DDR primitives with fixed primitive latency.
- Underrun:
  - Condition: in RUN, the buffer is empty when a pop is due.
  - underrun_count increments by 1 and saturates at 32'hFFFFFFFF.
  - dac_word becomes the last sample if HOLD_LAST=1, else 0.
  - State remains RUN. Streaming resumes on the next available entry with no re-prime.
- underrun_count clears on reset and on the IDLE-to-PRIME transition. It holds its value in IDLE.
- running = (state == RUN), registered.
- DDR mapping: pin j, D1 (rising) = dac_word[2j], D2 (falling) = dac_word[2j+1], SAME_EDGE mode.
- Forwarded clock: DDR output primitive with D1=1, D2=0.
- All outputs use differential output buffers.
- Reset applied mid-stream takes effect at the next edge with the reset values above. The DDR primitives are not reset; they emit 0 one cycle later.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, PRIME, RUN);
  - the saturate function, parameterised by input and output width;
  - the underrun counter width constant (32).
- Sub-module dac_oddr_bank wraps the per-pin DDR output register and differential output buffer instances plus the clock-forward pair, with a generate loop over DAC_DATA_WIDTH/2.
- axis_dac instantiates dac_oddr_bank and holds the FSM, skid buffer, saturation and counters.

Test Plan:
- Reset then enable=1 with a continuous stream of 0,1,2,...: tready=1 one cycle after PRIME is entered; dac_word shows 0,1,2,... starting 2 cycles after the first handshake; running=1; underrun_count=0.
- Saturation: send 16'sh7FFF, 16'sh8000, 16'sh1FFF, 16'shE000 -> dac_word 14'h1FFF, 14'h2000, 14'h1FFF, 14'h2000.
- Underrun with HOLD_LAST=1: send 5, then drop tvalid for 3 cycles -> dac_word held at 5 for those 3 cycles, underrun_count=3. Repeat with HOLD_LAST=0 -> dac_word=0 and underrun_count=3.
- Backpressure: tvalid held high while tready is toggled by buffer occupancy -> no beat lost or duplicated over 1000 random-gap beats; output order matches a scoreboard.
- Mid-stream disable: enable=0 with 2 beats buffered -> state IDLE, tready=0 next edge, dac_word=0, buffered beats dropped. Re-enable -> underrun_count cleared to 0.
- Pin check: dac_word=14'h2AAA -> every data pin shows 0 on the rising half and 1 on the falling half; dac_clk_p toggles in phase with aclk.
